// File: rtl/axi_read_master_pkg.sv
// Shared types and AXI constants for the single-outstanding AXI4 burst read engine.
package axi_read_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  // ARSIZE encoding for a full-width beat
  function automatic logic [2:0] axi_size(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered count; read data is the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read master: one INCR burst per {addr,len} request, beats buffered into a
// response FIFO tagged with last/err flags.
module axi_read_master import axi_read_master_pkg::*; #(
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ARUSER_WIDTH = 1,
  parameter int C_M_AXI_RUSER_WIDTH  = 4,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            REQ_VALID,
  output logic                            REQ_READY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [7:0]                      REQ_LEN,
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_DATA,
  output logic                            RSP_LAST,
  output logic                            RSP_ERR,
  output logic                            BUSY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0] M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]  M_AXI_RUSER,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int FW = DW + 2;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_alive;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                    r_len;
  logic [7:0]                    r_cnt;
  logic                          w_req_hs;
  logic                          w_r_hs;
  logic                          w_last_exp;
  logic                          w_err;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [FW-1:0]                 w_fifo_dout;
  logic                          w_unused;

  assign w_unused = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RRESP[0]};

  assign w_req_hs   = REQ_VALID && REQ_READY;
  assign w_r_hs     = M_AXI_RVALID && M_AXI_RREADY;
  assign w_last_exp = (r_cnt == r_len);
  // The beat count, not RLAST, decides where the burst ends
  assign w_err      = M_AXI_RRESP[1] || (M_AXI_RLAST != w_last_exp);

  // Holds REQ_READY low through reset and until the first clock after release
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (w_req_hs) begin
      r_addr <= REQ_ADDR;
      r_len  <= REQ_LEN;
      r_cnt  <= '0;
    end else if (w_r_hs) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    REQ_READY     = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        REQ_READY = r_alive;
        if (REQ_VALID && r_alive) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        M_AXI_RREADY = !w_fifo_full;
        if (M_AXI_RVALID && !w_fifo_full && w_last_exp) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = r_len;
  assign M_AXI_ARSIZE  = axi_size(C_M_AXI_DATA_WIDTH);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_DEFAULT;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .i_push  (w_r_hs),
    .i_data  ({w_err, w_last_exp, M_AXI_RDATA}),
    .i_pop   (RSP_READY),
    .o_data  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign RSP_VALID = !w_fifo_empty;
  assign RSP_DATA  = w_fifo_dout[DW-1:0];
  assign RSP_LAST  = w_fifo_dout[DW];
  assign RSP_ERR   = w_fifo_dout[DW+1];
  assign BUSY      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
